lamp_sequence_generator: RTL and testbench

//   Stimulus source for the lamp sequence detector: drives lamp1/lamp2/lamp3 one-hot in

---
 rtl/lamp_seq_pkg.sv | 39 +++
 rtl/lamp_seq_dwell_timer.sv | 31 +++
 rtl/lamp_sequence_generator.sv | 149 ++++++++++++++
 tb/tb_lamp_sequence_generator.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lamp_seq_pkg.sv
// Shared types and encodings for the lamp sequence generator.
// LAMP_GAP_EN selects the optional GAP state between lamp steps.
package lamp_seq_pkg;

  localparam int DW_W_DEF  = 8;
  localparam int REP_W_DEF = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_STEP_A = 3'd1;
  localparam state_t S_STEP_B = 3'd2;
  localparam state_t S_STEP_C = 3'd3;
  localparam state_t S_GAP    = 3'd4;
  localparam state_t S_DONE   = 3'd5;

  // {lamp3, lamp2, lamp1}
  localparam logic [2:0] LAMP_A   = 3'b001;
  localparam logic [2:0] LAMP_B_N = 3'b010;
  localparam logic [2:0] LAMP_C_N = 3'b100;
  localparam logic [2:0] LAMP_B_D = 3'b100;
  localparam logic [2:0] LAMP_C_D = 3'b010;

  function automatic logic [2:0] lamp_enc(
    input state_t s,
    input logic   dec
  );
    logic [2:0] l;
    l = '0;
    case (s)
      S_STEP_A: l = LAMP_A;
      S_STEP_B: l = dec ? LAMP_B_D : LAMP_B_N;
      S_STEP_C: l = dec ? LAMP_C_D : LAMP_C_N;
      default:  l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/lamp_seq_dwell_timer.sv
// Per-step dwell timer: loads D-1 on step entry, expires when it reaches 0.
// Shared by all lamp steps of lamp_sequence_generator (LAMP_GAP_EN-agnostic).
module lamp_dwell_timer #(
  parameter int DW_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [DW_W-1:0] val_i,
  output logic            expire_o
);

  logic [DW_W-1:0] cnt_q;
  logic [DW_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - DW_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/lamp_sequence_generator.sv
// Lamp stimulus FSM: 1-2-3 (or decoy 1-3-2) for D cycles x R passes.
// Define LAMP_GAP_EN to insert one dark GAP cycle between lamp steps.
module lamp_sequence_generator
  import lamp_seq_pkg::*;
#(
  parameter int DW_W  = DW_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [DW_W-1:0]  dwell,
  input  logic [REP_W-1:0] reps,
  input  logic             decoy,
  output logic             lamp1,
  output logic             lamp2,
  output logic             lamp3,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [DW_W-1:0]  d_q, d_d;
  logic [REP_W-1:0] rem_q, rem_d;
  logic             dec_q, dec_d;
  logic [2:0]       lamp_q;
  logic             busy_q, done_q;
`ifdef LAMP_GAP_EN
  state_t           nxt_q, nxt_d;
`endif

  logic             adv;
  state_t           tgt;
  logic [DW_W-1:0]  dwell_eff;
  logic [REP_W-1:0] reps_eff;
  logic             t_load;
  logic [DW_W-1:0]  t_val;
  logic             t_exp;

  assign dwell_eff = (dwell == '0) ? DW_W'(1) : dwell;
  assign reps_eff  = (reps == '0) ? REP_W'(1) : reps;

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    rem_d   = rem_q;
    dec_d   = dec_q;
    adv     = 1'b0;
    tgt     = S_IDLE;
`ifdef LAMP_GAP_EN
    nxt_d   = nxt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_STEP_A;
          d_d     = dwell_eff;
          rem_d   = reps_eff - REP_W'(1);
          dec_d   = decoy;
        end
      end
      S_STEP_A: begin
        adv = t_exp;
        tgt = S_STEP_B;
      end
      S_STEP_B: begin
        adv = t_exp;
        tgt = S_STEP_C;
      end
      S_STEP_C: begin
        if (t_exp) begin
          if (rem_q == '0) begin
            state_d = S_DONE;
          end else begin
            rem_d = rem_q - REP_W'(1);
            adv   = 1'b1;
            tgt   = S_STEP_A;
          end
        end
      end
`ifdef LAMP_GAP_EN
      S_GAP:   state_d = nxt_q;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
`ifdef LAMP_GAP_EN
      state_d = S_GAP;
      nxt_d   = tgt;
`else
      state_d = tgt;
`endif
    end
    if (abort && state_q != S_IDLE)
      state_d = S_IDLE;
  end

  // Reload the dwell timer on every fresh entry into a lamp step
  assign t_load = (state_d inside {S_STEP_A, S_STEP_B, S_STEP_C})
                  && (state_d != state_q);
  assign t_val  = (state_q == S_IDLE) ? dwell_eff - DW_W'(1)
                                      : d_q - DW_W'(1);

  lamp_dwell_timer #(
    .DW_W(DW_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (t_load),
    .val_i   (t_val),
    .expire_o(t_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      rem_q   <= '0;
      dec_q   <= 1'b0;
      lamp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      dec_q   <= dec_d;
      lamp_q  <= lamp_enc(state_d, dec_d);
      busy_q  <= state_d inside {S_STEP_A, S_STEP_B, S_STEP_C, S_GAP};
      done_q  <= (state_d == S_DONE);
    end
  end

`ifdef LAMP_GAP_EN
  always_ff @(posedge clk) begin
    if (reset) nxt_q <= S_IDLE;
    else       nxt_q <= nxt_d;
  end
`endif

  assign lamp1 = lamp_q[0];
  assign lamp2 = lamp_q[1];
  assign lamp3 = lamp_q[2];
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_lamp_sequence_generator.sv
// Directed bench for lamp_sequence_generator.
// Expectations follow LAMP_GAP_EN when the bench is built with it.
module tb_lamp_sequence_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] dwell;
  logic [3:0] reps;
  logic       decoy;
  logic       lamp1, lamp2, lamp3, busy, done;

  int checks = 0;
  int errors = 0;

  lamp_sequence_generator dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .dwell(dwell),
    .reps (reps),
    .decoy(decoy),
    .lamp1(lamp1),
    .lamp2(lamp2),
    .lamp3(lamp3),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Advance one cycle; start is always a single-cycle pulse
  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // exp = {done, busy, lamp3, lamp2, lamp1}
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {done, busy, lamp3, lamp2, lamp1};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic gap_chk(input string tag);
`ifdef LAMP_GAP_EN
    tick();
    chk({tag, "_gap"}, 5'b01000);
`endif
  endtask

  task automatic run(input string tag, input logic [7:0] dw,
                     input logic [3:0] rp, input logic dc,
                     input int de, input int re);
    logic [2:0] pat;
    bit first;
    dwell = dw;
    reps  = rp;
    decoy = dc;
    start = 1'b1;
    first = 1'b1;
    for (int p = 0; p < re; p++) begin
      for (int s = 0; s < 3; s++) begin
        if (s == 0)      pat = 3'b001;
        else if (s == 1) pat = dc ? 3'b100 : 3'b010;
        else             pat = dc ? 3'b010 : 3'b100;
        for (int c = 0; c < de; c++) begin
          tick();
          if (first) begin
            dwell = 8'd200;
            reps  = 4'd9;
            decoy = ~dc;
            first = 1'b0;
          end
          chk(tag, {2'b01, pat});
          if (p == 0 && s == 1 && c == 0) start = 1'b1;
        end
        if (!(p == re - 1 && s == 2)) gap_chk(tag);
      end
    end
    start = 1'b1;
    tick();
    chk({tag, "_done"}, 5'b10000);
    start = 1'b1;
    tick();
    chk({tag, "_idle1"}, 5'b00000);
    tick();
    chk({tag, "_idle2"}, 5'b00000);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    dwell = '0;
    reps  = '0;
    decoy = 1'b0;
    tick();
    tick();
    chk("reset", 5'b00000);
    reset = 1'b0;
    tick();
    chk("idle", 5'b00000);

    // reset asserted for 2 cycles while in STEP_B
    dwell = 8'd3;
    reps  = 4'd1;
    decoy = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_a", 5'b01001);
    end
    gap_chk("rst");
    tick();
    chk("rst_b", 5'b01010);
    reset = 1'b1;
    tick();
    chk("rst_mid1", 5'b00000);
    tick();
    chk("rst_mid2", 5'b00000);
    reset = 1'b0;
    tick();
    chk("rst_after", 5'b00000);

    run("d1r1", 8'd1, 4'd1, 1'b0, 1, 1);
    run("d3r2dec", 8'd3, 4'd2, 1'b1, 3, 2);
    run("d0r0", 8'd0, 4'd0, 1'b0, 1, 1);
    run("gap_d1r2", 8'd1, 4'd2, 1'b0, 1, 2);
    run("rmax", 8'd1, 4'd15, 1'b1, 1, 15);
    run("dmax", 8'd255, 4'd1, 1'b0, 255, 1);

    // abort on 2nd cycle of STEP_B
    dwell = 8'd4;
    reps  = 4'd1;
    decoy = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("ab_a", 5'b01001);
    end
    gap_chk("ab");
    tick();
    chk("ab_b1", 5'b01010);
    tick();
    chk("ab_b2", 5'b01010);
    abort = 1'b1;
    tick();
    chk("ab_now", 5'b00000);
    start = 1'b1;
    tick();
    chk("ab_start", 5'b00000);
    abort = 1'b0;
    tick();
    chk("ab_idle", 5'b00000);
    tick();
    chk("ab_nodone", 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
